// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - opcode, ALU control encodings, FSM state and control bundle types.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    OPC_ADD  = 3'b000,
    OPC_SUB  = 3'b001,
    OPC_ANDB = 3'b010,
    OPC_XOR  = 3'b011,
    OPC_SHL  = 3'b100,
    OPC_SHR  = 3'b101,
    OPC_BRC  = 3'b110,
    OPC_SYS  = 3'b111
  } opcode_e;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_ANDB  = 2'b01;
  localparam logic [1:0] ALU_OP_XOR   = 2'b10;
  localparam logic [1:0] ALU_OP_SHIFT = 2'b11;

  localparam logic [1:0] BSEL_ZERO  = 2'b00;
  localparam logic [1:0] BSEL_SIGN  = 2'b01;
  localparam logic [1:0] BSEL_OVF   = 2'b10;
  localparam logic [1:0] BSEL_ZERO2 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       sub;
    logic       branch;
    logic [1:0] branch_sel;
    logic       shift_left;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/alu_ctrl_lut.sv
// rtl/alu_ctrl_lut.sv - combinational instruction to ALU control decode.
module alu_ctrl_lut
  import alu_ctrl_pkg::*;
#(
  parameter int INSTR_W = 9
) (
  input  logic [INSTR_W-1:0] instr,
  output ctrl_t              ctrl,
  output logic               is_nop,
  output logic               is_halt
);

  opcode_e            opc;
  logic [INSTR_W-4:0] operand;

  assign opc     = opcode_e'(instr[INSTR_W-1 -: 3]);
  assign operand = instr[INSTR_W-4:0];

  always_comb begin
    ctrl    = CTRL_NONE;
    is_nop  = 1'b0;
    is_halt = 1'b0;
    case (opc)
      OPC_ADD:  ctrl.alu_op = ALU_OP_ADD;
      OPC_SUB:  begin ctrl.alu_op = ALU_OP_ADD; ctrl.sub = 1'b1; end
      OPC_ANDB: ctrl.alu_op = ALU_OP_ANDB;
      OPC_XOR:  ctrl.alu_op = ALU_OP_XOR;
      OPC_SHL:  begin ctrl.alu_op = ALU_OP_SHIFT; ctrl.shift_left = 1'b1; end
      OPC_SHR:  ctrl.alu_op = ALU_OP_SHIFT;
      OPC_BRC: begin
        // Branch compares by subtraction; the flag picked by branch_sel is returned on alu_out[0].
        ctrl.alu_op     = ALU_OP_ADD;
        ctrl.sub        = 1'b1;
        ctrl.branch     = 1'b1;
        ctrl.branch_sel = operand[INSTR_W-4 -: 2];
      end
      OPC_SYS: begin
        is_nop  = (operand == '0);
        is_halt = (operand != '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_decoder.sv
// rtl/alu_ctrl_decoder.sv - ALU control FSM with registered controls and branch resolve.
// Optional retired-instruction counter enabled by ALU_CTRL_PERF_CNT_EN.
module alu_ctrl_decoder
  import alu_ctrl_pkg::*;
#(
  parameter int INSTR_W = 9,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic               ctrl_valid,
  input  logic               ex_ready,
  output logic [1:0]         alu_op,
  output logic               sub,
  output logic               branch,
  output logic [1:0]         branch_sel,
  output logic               shift_left,
  input  logic [7:0]         alu_out,
  output logic               branch_done,
  output logic               branch_taken,
`ifdef ALU_CTRL_PERF_CNT_EN
  output logic               halted,
  output logic [CNT_W-1:0]   retired_cnt
`else
  output logic               halted
`endif
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  ctrl_t  lut_ctrl;
  logic   lut_nop, lut_halt;
  logic   instr_ready_q, instr_ready_d;
  logic   ctrl_valid_q, ctrl_valid_d;
  logic   branch_done_q, branch_done_d;
  logic   branch_taken_q, branch_taken_d;
  logic   halted_q, halted_d;
  logic   accept, retire;

  alu_ctrl_lut #(.INSTR_W(INSTR_W)) u_lut (
    .instr   (instr),
    .ctrl    (lut_ctrl),
    .is_nop  (lut_nop),
    .is_halt (lut_halt)
  );

  assign accept = instr_valid & instr_ready_q;

  always_comb begin
    state_d        = state_q;
    ctrl_d         = ctrl_q;
    branch_done_d  = 1'b0;
    branch_taken_d = 1'b0;
    retire         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (lut_halt) begin
            state_d = ST_HALT;
          end else if (lut_nop) begin
            retire = 1'b1;
          end else begin
            ctrl_d  = lut_ctrl;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (ex_ready) begin
          if (ctrl_q.branch) begin
            state_d = ST_RESOLVE;
          end else begin
            state_d = ST_IDLE;
            retire  = 1'b1;
          end
        end
      end
      ST_RESOLVE: begin
        // Controls stay on the ALU so alu_out[0] still reflects the selected flag here.
        branch_done_d  = 1'b1;
        branch_taken_d = alu_out[0];
        retire         = 1'b1;
        state_d        = ST_IDLE;
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
    instr_ready_d = (state_d == ST_IDLE);
    ctrl_valid_d  = (state_d == ST_EXEC);
    halted_d      = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      ctrl_q         <= CTRL_NONE;
      instr_ready_q  <= 1'b0;
      ctrl_valid_q   <= 1'b0;
      branch_done_q  <= 1'b0;
      branch_taken_q <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      ctrl_q         <= ctrl_d;
      instr_ready_q  <= instr_ready_d;
      ctrl_valid_q   <= ctrl_valid_d;
      branch_done_q  <= branch_done_d;
      branch_taken_q <= branch_taken_d;
      halted_q       <= halted_d;
    end
  end

`ifdef ALU_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

  always_comb begin
    retired_cnt_d = retired_cnt_q + CNT_W'(retire);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) retired_cnt_q <= '0;
    else        retired_cnt_q <= retired_cnt_d;
  end

  assign retired_cnt = retired_cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  logic             unused_retire;
  assign unused_cnt_w  = '0;
  assign unused_retire = retire;
`endif

  logic unused_alu_bits;
  assign unused_alu_bits = ^alu_out[7:1];

  assign instr_ready  = instr_ready_q;
  assign ctrl_valid   = ctrl_valid_q;
  assign alu_op       = ctrl_q.alu_op;
  assign sub          = ctrl_q.sub;
  assign branch       = ctrl_q.branch;
  assign branch_sel   = ctrl_q.branch_sel;
  assign shift_left   = ctrl_q.shift_left;
  assign branch_done  = branch_done_q;
  assign branch_taken = branch_taken_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// tb/tb_alu_ctrl_decoder.sv - table, directed and random checks of alu_ctrl_decoder against a behavioural model.
module tb_alu_ctrl_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] instr = '0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic       ctrl_valid;
  logic       ex_ready = 1'b0;
  logic [1:0] alu_op;
  logic       sub;
  logic       branch;
  logic [1:0] branch_sel;
  logic       shift_left;
  logic [7:0] alu_out = '0;
  logic       branch_done;
  logic       branch_taken;
  logic       halted;
`ifdef ALU_CTRL_PERF_CNT_EN
  logic [15:0] retired_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_ctrl_decoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .ctrl_valid   (ctrl_valid),
    .ex_ready     (ex_ready),
    .alu_op       (alu_op),
    .sub          (sub),
    .branch       (branch),
    .branch_sel   (branch_sel),
    .shift_left   (shift_left),
    .alu_out      (alu_out),
    .branch_done  (branch_done),
    .branch_taken (branch_taken),
`ifdef ALU_CTRL_PERF_CNT_EN
    .halted       (halted),
    .retired_cnt  (retired_cnt)
`else
    .halted       (halted)
`endif
  );

  // Behavioural model: phase 0 idle, 1 controls offered, 2 branch resolving, 3 halted.
  int          m_phase = 0;
  logic        m_ready = 0, m_cvalid = 0, m_done = 0, m_taken = 0, m_halted = 0;
  logic [1:0]  m_op = 0, m_bsel = 0;
  logic        m_sub = 0, m_br = 0, m_shl = 0;
  int unsigned m_cnt = 0;
  logic [1:0]  op_of [8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};

  task automatic model_edge();
    int opc;
    logic [5:0] low;
    if (!rst_n) begin
      m_phase = 0; m_ready = 0; m_cvalid = 0; m_done = 0; m_taken = 0; m_halted = 0;
      m_op = 0; m_bsel = 0; m_sub = 0; m_br = 0; m_shl = 0; m_cnt = 0;
      return;
    end
    m_done = 0;
    m_taken = 0;
    opc = int'(instr[8:6]);
    low = instr[5:0];
    case (m_phase)
      0: if (instr_valid && m_ready) begin
        if (opc == 7) begin
          if (low == 0) m_cnt++;
          else m_phase = 3;
        end else begin
          m_op   = op_of[opc];
          m_sub  = (opc == 1 || opc == 6);
          m_br   = (opc == 6);
          m_bsel = (opc == 6) ? low[5:4] : 2'd0;
          m_shl  = (opc == 4);
          m_phase = 1;
        end
      end
      1: if (ex_ready) begin
        if (m_br) m_phase = 2;
        else begin m_phase = 0; m_cnt++; end
      end
      2: begin m_done = 1; m_taken = alu_out[0]; m_cnt++; m_phase = 0; end
      default: ;
    endcase
    m_ready  = (m_phase == 0);
    m_cvalid = (m_phase == 1);
    m_halted = (m_phase == 3);
  endtask

  function automatic logic [11:0] dut_vec();
    return {instr_ready, ctrl_valid, alu_op, sub, branch, branch_sel, shift_left,
            branch_done, branch_done & branch_taken, halted};
  endfunction

  function automatic logic [11:0] model_vec();
    return {m_ready, m_cvalid, m_op, m_sub, m_br, m_bsel, m_shl, m_done, m_done & m_taken, m_halted};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model", 32'(dut_vec()), 32'(model_vec()));
`ifdef ALU_CTRL_PERF_CNT_EN
    check("retired_cnt_model", 32'(retired_cnt), 32'(m_cnt[15:0]));
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    instr_valid = 1'b0;
    ex_ready = 1'b0;
    tick();
    check("reset_outputs", 32'(dut_vec()), 32'h0);
    rst_n = 1'b1;
    tick();
    check("ready_after_reset", 32'(instr_ready), 32'h1);
  endtask

  typedef struct {
    logic [8:0] instr;
    logic [6:0] exp_ctrl;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{9'b000_101010, 7'b00_0_0_00_0};
    vecs[1] = '{9'b001_000000, 7'b00_1_0_00_0};
    vecs[2] = '{9'b010_111111, 7'b01_0_0_00_0};
    vecs[3] = '{9'b011_000001, 7'b10_0_0_00_0};
    vecs[4] = '{9'b100_000000, 7'b11_0_0_00_1};
    vecs[5] = '{9'b101_110011, 7'b11_0_0_00_0};
    vecs[6] = '{9'b110_000000, 7'b00_1_1_00_0};
    vecs[7] = '{9'b110_010000, 7'b00_1_1_01_0};
    vecs[8] = '{9'b110_100101, 7'b00_1_1_10_0};
    vecs[9] = '{9'b110_111111, 7'b00_1_1_11_0};

    do_reset();

    // Decode table: accept, check controls one cycle later, then drain.
    for (int i = 0; i < 10; i++) begin
      instr = vecs[i].instr;
      instr_valid = 1'b1;
      ex_ready = 1'b1;
      tick();
      instr_valid = 1'b0;
      check("tbl_ctrl_valid", 32'(ctrl_valid), 32'h1);
      check("tbl_ctrl", 32'({alu_op, sub, branch, branch_sel, shift_left}), 32'(vecs[i].exp_ctrl));
      tick(); tick(); tick();
      check("tbl_ready_again", 32'(instr_ready), 32'h1);
    end

    // SUB latency and return to ready.
    do_reset();
    instr = 9'b001_000000; instr_valid = 1'b1; ex_ready = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("sub_ctrl_valid", 32'(ctrl_valid), 32'h1);
    check("sub_ctrls", 32'({alu_op, sub}), 32'b00_1);
    check("sub_not_ready", 32'(instr_ready), 32'h0);
    tick();
    check("sub_ready_n2", 32'(instr_ready), 32'h1);

    // SHL held while execute stalls.
    instr = 9'b100_000000; instr_valid = 1'b1; ex_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("shl_hold", 32'({ctrl_valid, shift_left, instr_ready}), 32'b110);
    end
    instr_valid = 1'b0; ex_ready = 1'b1;
    tick();
    check("shl_release", 32'({ctrl_valid, instr_ready}), 32'b01);

    // Branch taken, then not taken.
    for (int t = 1; t >= 0; t--) begin
      instr = 9'b110_010000; instr_valid = 1'b1; ex_ready = 1'b1; alu_out = 8'h00;
      tick();
      instr_valid = 1'b0;
      check("brc_ctrls", 32'({ctrl_valid, branch, branch_sel, sub}), 32'b1_1_01_1);
      tick();
      check("brc_resolve", 32'({ctrl_valid, branch, branch_done}), 32'b0_1_0);
      alu_out = 8'(t);
      tick();
      check("brc_done", 32'({branch_done, branch_taken}), 32'({1'b1, 1'(t)}));
      tick();
      check("brc_pulse_end", 32'(branch_done), 32'h0);
    end

    // NOP then HALT; later requests ignored.
    instr = 9'b111_000000; instr_valid = 1'b1;
    tick();
    check("nop_no_ctrl", 32'({ctrl_valid, instr_ready}), 32'b01);
    instr = 9'b111_000001;
    tick();
    check("halt_set", 32'({halted, instr_ready}), 32'b10);
    instr = 9'b000_000000; ex_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("halt_ignores", 32'({halted, ctrl_valid, instr_ready}), 32'b100);
    end

    // Reset mid-EXEC and in RESOLVE.
    do_reset();
    instr = 9'b011_000000; instr_valid = 1'b1; ex_ready = 1'b0;
    tick();
    instr_valid = 1'b0;
    check("xor_exec", 32'({ctrl_valid, alu_op}), 32'b1_10);
    rst_n = 1'b0;
    tick();
    check("rst_in_exec", 32'(dut_vec()), 32'h0);
    rst_n = 1'b1;
    tick();
    instr = 9'b110_000000; instr_valid = 1'b1; ex_ready = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    rst_n = 1'b0; alu_out = 8'h01;
    tick();
    check("rst_in_resolve", 32'({branch_done, branch_taken, branch}), 32'b000);
    rst_n = 1'b1;
    tick();

`ifdef ALU_CTRL_PERF_CNT_EN
    do_reset();
    ex_ready = 1'b1; alu_out = 8'h00;
    instr = 9'b000_000011; instr_valid = 1'b1; tick(); instr_valid = 1'b0; tick();
    instr = 9'b110_000000; instr_valid = 1'b1; tick(); instr_valid = 1'b0; tick(); tick();
    instr = 9'b111_000000; instr_valid = 1'b1; tick();
    instr = 9'b011_000000; tick(); instr_valid = 1'b0; tick();
    check("perf_cnt_four", 32'(retired_cnt), 32'd4);
`endif

    // Randomised traffic with occasional resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_n       = ($urandom_range(0, 39) != 0);
      instr       = 9'($urandom);
      instr_valid = ($urandom_range(0, 9) < 7);
      ex_ready    = ($urandom_range(0, 9) < 6);
      alu_out     = 8'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
